// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, ALU opcodes, multiply sequencer state.
// Imported by the ALU interface, the multiply sequencer and its bench.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mulstate_t;

    parameter int MUL_ITER = 32;

endpackage

// File: rtl/alu_if.sv
// Shared ALU port bundle: operands and opcode in, result and flags out.
// Modports: alu (the ALU itself), tb (a block that borrows the ALU).
interface alu_if;
    import cpu_types_pkg::*;

    word_t  porta;
    word_t  portb;
    aluop_t op;
    word_t  out;
    logic   nf;
    logic   zf;
    logic   of;

    modport alu (
        input  porta, portb, op,
        output out, nf, zf, of
    );

    modport tb (
        output porta, portb, op,
        input  out, nf, zf, of
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-and-add multiplier (low 32 bits) using the shared ALU.
// Ports: CLK, nRST (async low), start, mcand, mplier, busy, done,
// product, aluif (alu_if.tb). Option: MUL_EARLY_EXIT_EN stops RUN
// once the remaining multiplier bits are all zero.
import cpu_types_pkg::*;

module mul_seq (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  start,
    input  word_t mcand,
    input  word_t mplier,
    output logic  busy,
    output logic  done,
    output word_t product,
    alu_if.tb     aluif
);

    localparam logic [4:0] CNT_LAST = 5'(MUL_ITER - 1);

    mulstate_t  state;
    word_t      a;
    word_t      b;
    word_t      acc;
    logic [4:0] cnt;
    logic       last;

    // Only the adder is borrowed; shifts stay local.
    always_comb begin
        aluif.porta = '0;
        aluif.portb = '0;
        aluif.op    = ALU_ADD;
        if (state == RUN) begin
            aluif.porta = acc;
            aluif.portb = b[0] ? a : '0;
        end
    end

`ifdef MUL_EARLY_EXIT_EN
    // No set bits left after this shift: the rest would add zero.
    assign last = (cnt == CNT_LAST) || ((b >> 1) == '0);
`else
    assign last = (cnt == CNT_LAST);
`endif

    assign product = acc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a     <= mcand;
                        b     <= mplier;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= aluif.out;
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt + 5'd1;
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: timeline model of accept/run/done plus product
// arithmetic, checked every cycle, with directed literal cases.
module tb_mul_seq;
    import cpu_types_pkg::*;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  nrst = 1'b0;
    logic  start = 1'b0;
    word_t mcand = '0;
    word_t mplier = '0;
    logic  busy;
    logic  done;
    word_t product;
    logic  of_t = 1'b0;

    alu_if aluif ();

    assign aluif.out = aluif.porta + aluif.portb;
    assign aluif.nf  = aluif.out[31];
    assign aluif.zf  = (aluif.out == '0);
    assign aluif.of  = of_t;

    mul_seq dut (
        .CLK    (clk),
        .nRST   (nrst),
        .start  (start),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .product(product),
        .aluif  (aluif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) of_t <= ~of_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int run_len(input word_t mp);
        if (!EE) return 32;
        for (int i = 31; i >= 0; i--)
            if (mp[i]) return i + 1;
        return 1;
    endfunction

    // Model: an accepted start at edge k gives RUN for rl cycles,
    // DONE in the next, then IDLE; product is the truncated product.
    int    cyc = 0;
    bit    act = 1'b0;
    int    acc_cyc = 0;
    int    rl = 0;
    word_t res = '0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            act = 1'b0;
            res = '0;
        end else begin
            cyc++;
            if (start && (!act || (cyc - 1 - acc_cyc) >= rl + 1)) begin
                act     = 1'b1;
                acc_cyc = cyc;
                rl      = run_len(mplier);
                res     = word_t'(64'(mcand) * 64'(mplier));
            end
        end
    end

    always @(negedge clk) begin
        int d;
        bit eb;
        bit ed;
        d  = cyc - acc_cyc;
        eb = act && (d < rl);
        ed = act && (d == rl);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("alu op", aluif.op, ALU_ADD);
        if (!eb) begin
            chk("product", product, act ? res : 32'h0);
            chk("idle porta", aluif.porta, 0);
            chk("idle portb", aluif.portb, 0);
        end
    end

    task automatic do_op(input string nm, input word_t mc, input word_t mp,
                         input word_t exp_p, input int lat_n,
                         input int lat_e);
        int n;
        @(negedge clk);
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, EE ? lat_e : lat_n);
        chk({nm, " product"}, product, exp_p);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset product", product, 0);
        #1 nrst = 1'b1;

        do_op("3x5", 32'd3, 32'd5, 32'd15, 33, 4);
        do_op("m1xm2", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h2, 33, 33);
        do_op("msbx2", 32'h8000_0000, 32'd2, 32'h0, 33, 3);
        do_op("16x16", 32'h1_0000, 32'h1_0000, 32'h0, 33, 18);
        do_op("mp0", 32'h1234_5678, 32'h0, 32'h0, 33, 2);
        do_op("mc0", 32'h0, 32'hFFFF_FFFF, 32'h0, 33, 33);

        // Reset while running discards the partial result.
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'd7;
        mplier = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (EE ? 1 : 9) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("midrun rst busy", busy, 0);
        chk("midrun rst done", done, 0);
        chk("midrun rst product", product, 0);
        @(negedge clk);
        #1 nrst = 1'b1;
        do_op("7x9", 32'd7, 32'd9, 32'd63, 33, 5);

        // start held high with operands changing every cycle
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start  = 1'b1;
            mcand  = $urandom;
            mplier = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            mcand = $urandom;
            case ($urandom_range(0, 3))
                0: mplier = $urandom;
                1: mplier = 32'($urandom_range(0, 15));
                2: mplier = 32'h0;
                default: mplier = 32'h1 << $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 499) == 0) begin
                #1 nrst = 1'b0;
                @(negedge clk);
                #1 nrst = 1'b1;
            end
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative multiply sequencer that owns the shared ALU through `alu_if` and computes the low 32 bits of `mcand * mplier` by shift-and-add. The operand shifts are done locally. Each addition goes through the ALU with `ALU_ADD`. It sits beside the execute stage: the pipeline stalls on `busy` and takes `product` when `done` pulses. Signed and unsigned MUL share this block, because the low 32 bits of a two's-complement product are sign-agnostic.

## Interface
- No parameters. Iteration count is the package constant `MUL_ITER` = 32.
- `CLK`  in  1  — clock; all state updates on the rising edge.
- `nRST`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request. Sampled only in IDLE; ignored otherwise.
- `mcand`  in  32 (`word_t`)  — multiplicand, captured on the accepted `start`.
- `mplier`  in  32 (`word_t`)  — multiplier, captured on the accepted `start`.
- `busy`  out  1  — high in RUN.
- `done`  out  1  — one-cycle pulse in DONE.
- `product`  out  32 (`word_t`)  — result. Valid from `done` until the next accepted `start`.
- `aluif`  `alu_if.tb`  — block drives `porta`, `portb`, `op`; reads `out`. `nf`, `zf` and `of` are ignored.

## Operation
- State register `mulstate_t`: IDLE, RUN, DONE.
- Internal registers: `a` (32), `b` (32), `acc` (32), `cnt` (5 bits).
- **IDLE**
  - On `start`=1: `a`<=`mcand`, `b`<=`mplier`, `acc`<=0, `cnt`<=0, go to RUN.
  - Otherwise hold all registers.
- **RUN** (one iteration per cycle)
  - ALU drive: `porta`=`acc`, `portb`=`b[0]` ? `a` : 0, `op`=`ALU_ADD`.
  - Edge updates: `acc`<=`aluif.out`, `a`<=`a`<<1, `b`<=`b`>>1 (logical), `cnt`<=`cnt`+1.
  - Arithmetic is mod 2^32. Carry-out and `of` are discarded.
  - Go to DONE when `cnt`==31.
- **DONE**
  - `done`=1 for exactly one cycle, then unconditionally IDLE.
  - `product` is a direct view of `acc` and stays stable until the next accepted `start` clears `acc`.
- ALU drive outside RUN: `porta`=0, `portb`=0, `op`=`ALU_ADD`. The ALU is free for no one else; muxing it with the execute stage is done outside this block, keyed on `busy`.
- `start` while in RUN or DONE is ignored. It is not queued.
- Reset at any time, including mid-RUN: asynchronous return to IDLE. The partial result is discarded.
- Reset values: state IDLE; `a`, `b`, `acc`, `cnt` = 0; `busy`=0, `done`=0, `product`=0.

## Timing
- Edge E0: `start` sampled high in IDLE.
- Cycles E0+1 … E0+32: RUN, with `busy`=1.
- Cycle after the final RUN edge: DONE, with `done`=1 and `product` valid.
- Next cycle: IDLE. The earliest next `start` is sampled on the edge that leaves DONE+1, i.e. a back-to-back request costs one IDLE cycle.
- Without early exit:
  - Start-to-`done` latency is a fixed 33 cycles.
  - Throughput is one multiply per 34 cycles.
- The ALU path is combinational within a RUN cycle. `acc` is the only register in the loop.

## Configuration
- Macro: `MUL_EARLY_EXIT_EN`.
- Defined:
  - RUN also exits to DONE when the next value of `b` (`b`>>1) is 0.
  - RUN length equals `max(1, index of highest set bit of mplier + 1)`. For example, `mplier`=0 or 1 takes 1 RUN cycle; `mplier`=5 takes 3 RUN cycles.
  - The `cnt`==31 exit is still present.
  - `product` is identical to the non-early-exit result.
- Undefined: always exactly 32 RUN cycles.

## Structure
- Add to `cpu_types_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mulstate_t`
  - `parameter MUL_ITER = 32`
- Reuse the existing `word_t` and `aluop_t` (`ALU_ADD`).
- Single module with no sub-module. The shift and select logic is too small to split out.

## Test plan
- Reset mid-RUN: `mcand`=7, `mplier`=9, pulse `nRST` low at RUN cycle 10 → immediate IDLE, `busy`=0, `product`=0, no `done`. A new `start` then yields 63.
- `mcand`=3, `mplier`=5 → `product`=15. `done` at 33 cycles without the macro and at 4 cycles with it (3 RUN + DONE). `busy` is high only during RUN.
- Signed/wrap: `mcand`=0xFFFFFFFF (−1), `mplier`=0xFFFFFFFE (−2) → `product`=0x00000002. The ALU `of` toggling has no effect.
- Overflow truncation: `mcand`=0x80000000, `mplier`=2 → `product`=0. `mcand`=0x10000, `mplier`=0x10000 → `product`=0.
- Zero operands: `mplier`=0 → `product`=0, 1 RUN cycle with the macro. `mcand`=0, `mplier`=0xFFFFFFFF → 0 after 32 RUN cycles in both builds.
- Protocol: `start` held high continuously with changing operands → the second start is accepted only in IDLE after DONE. Operands changed during RUN do not affect `product`. In IDLE, ALU drive is `porta`=0, `portb`=0, `op`=`ALU_ADD`.
